mem_bist_ctrl: RTL

//  Built-in self-test sequencer that sits directly upstream of the single-port memory.

---
 rtl/mem_bist_ctrl_pkg.sv | 30 +++
 rtl/mem_bist_cmp.sv | 68 ++++++
 rtl/mem_bist_ctrl.sv | 139 +++++++++++++
 3 files changed

// File: rtl/mem_bist_ctrl_pkg.sv
// Shared sizing and FSM encoding for the memory BIST sequencer.
// DEPTH/WIDTH default to 16 unless the build already defines `DEPTH/`WIDTH.
`ifndef DEPTH
`define DEPTH 16
`endif
`ifndef WIDTH
`define WIDTH 16
`endif

package mem_bist_ctrl_pkg;

  localparam int DEPTH  = `DEPTH;
  localparam int WIDTH  = `WIDTH;
  localparam int ADDR_W = $clog2(DEPTH);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WR_ASC  = 3'd1,
    ST_RD_ASC  = 3'd2,
    ST_WR_DESC = 3'd3,
    ST_RD_DESC = 3'd4,
    ST_DRAIN   = 3'd5,
    ST_DONE    = 3'd6
  } bist_state_e;

  function automatic logic is_busy(bist_state_e s);
    return (s != ST_IDLE) && (s != ST_DONE);
  endfunction

endpackage

// File: rtl/mem_bist_cmp.sv
// Read-compare pipeline: registered expected word, chk flag, saturating error counter.
// Optional first-fail capture when BIST_FAIL_CAPTURE_EN is defined.
module mem_bist_cmp
  import mem_bist_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_W,
  parameter int ERR_W      = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear,
  input  logic                  rd_issue,
  input  logic [WIDTH-1:0]      exp_word,
`ifdef BIST_FAIL_CAPTURE_EN
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [ADDR_WIDTH-1:0] fail_addr,
  output logic [WIDTH-1:0]      fail_data,
`endif
  input  logic [WIDTH-1:0]      rdata,
  input  logic                  ready,
  output logic [ERR_W-1:0]      err_cnt
);

  logic             chk;
  logic [WIDTH-1:0] exp_word_q;
  logic             mismatch;

  // A missing ready on a pending compare is a protocol fault and counts as one error.
  assign mismatch = chk && (!ready || (rdata != exp_word_q));

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      chk        <= 1'b0;
      exp_word_q <= '0;
    end else begin
      chk        <= rd_issue;
      exp_word_q <= rd_issue ? exp_word : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      err_cnt <= '0;
    end else if (mismatch && (err_cnt != {ERR_W{1'b1}})) begin
      err_cnt <= err_cnt + 1'b1;
    end
  end

`ifdef BIST_FAIL_CAPTURE_EN
  logic [ADDR_WIDTH-1:0] chk_addr;

  // err_cnt==0 marks the first mismatch since the last start.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      chk_addr  <= '0;
      fail_addr <= '0;
      fail_data <= '0;
    end else begin
      chk_addr <= rd_issue ? rd_addr : '0;
      if (mismatch && (err_cnt == '0)) begin
        fail_addr <= chk_addr;
        fail_data <= rdata;
      end
    end
  end
`endif

endmodule

// File: rtl/mem_bist_ctrl.sv
// Four-phase march BIST sequencer driving a single-port memory request interface.
// Define BIST_FAIL_CAPTURE_EN to add fail_addr_o/fail_data_o first-mismatch capture.
module mem_bist_ctrl
  import mem_bist_ctrl_pkg::*;
#(
  parameter int               ADDR_WIDTH = ADDR_W,
  parameter logic [WIDTH-1:0] PATTERN    = 16'hA5A5,
  parameter int               ERR_W      = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  pass_o,
  output logic [ERR_W-1:0]      err_cnt_o,
  output logic                  mem_valid_o,
  output logic                  mem_w_r_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [WIDTH-1:0]      mem_wdata_o,
  input  logic [WIDTH-1:0]      mem_rdata_i,
  input  logic                  mem_ready_i,
`ifdef BIST_FAIL_CAPTURE_EN
  output logic [ADDR_WIDTH-1:0] fail_addr_o,
  output logic [WIDTH-1:0]      fail_data_o,
`endif
  output bist_state_e           state_o
);

  // Handshake: a request is issued in every cycle mem_valid_o=1; the memory
  // answers with mem_ready_i (and mem_rdata_i for reads) exactly one cycle later.

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

  bist_state_e           state, state_n;
  logic [ADDR_WIDTH-1:0] addr, addr_n;
  logic                  start_ok;
  logic [WIDTH-1:0]      exp_word;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      addr  <= '0;
    end else begin
      state <= state_n;
      addr  <= addr_n;
    end
  end

  always_comb begin
    state_n     = state;
    addr_n      = addr;
    start_ok    = 1'b0;
    mem_valid_o = 1'b0;
    mem_w_r_o   = 1'b0;
    mem_wdata_o = '0;
    exp_word    = '0;
    case (state)
      ST_IDLE, ST_DONE: begin
        if (start_i) begin
          start_ok = 1'b1;
          state_n  = ST_WR_ASC;
          addr_n   = '0;
        end
      end
      ST_WR_ASC: begin
        mem_valid_o = 1'b1;
        mem_w_r_o   = 1'b1;
        mem_wdata_o = PATTERN;
        if (addr == LAST_ADDR) begin
          state_n = ST_RD_ASC;
          addr_n  = '0;
        end else begin
          addr_n = addr + 1'b1;
        end
      end
      ST_RD_ASC: begin
        mem_valid_o = 1'b1;
        exp_word    = PATTERN;
        if (addr == LAST_ADDR) begin
          state_n = ST_WR_DESC;
          addr_n  = LAST_ADDR;
        end else begin
          addr_n = addr + 1'b1;
        end
      end
      ST_WR_DESC: begin
        mem_valid_o = 1'b1;
        mem_w_r_o   = 1'b1;
        mem_wdata_o = ~PATTERN;
        if (addr == '0) begin
          state_n = ST_RD_DESC;
          addr_n  = LAST_ADDR;
        end else begin
          addr_n = addr - 1'b1;
        end
      end
      ST_RD_DESC: begin
        mem_valid_o = 1'b1;
        exp_word    = ~PATTERN;
        if (addr == '0) begin
          state_n = ST_DRAIN;
          addr_n  = '0;
        end else begin
          addr_n = addr - 1'b1;
        end
      end
      // One idle cycle so the last read's compare lands before DONE.
      ST_DRAIN: state_n = ST_DONE;
      default:  state_n = ST_IDLE;
    endcase
  end

  assign mem_addr_o = addr;
  assign busy_o     = is_busy(state);
  assign done_o     = (state == ST_DONE);
  assign pass_o     = done_o && (err_cnt_o == '0);
  assign state_o    = state;

  mem_bist_cmp #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .ERR_W      (ERR_W)
  ) u_cmp (
    .clk       (clk),
    .rst       (rst),
    .clear     (start_ok),
    .rd_issue  (mem_valid_o && !mem_w_r_o),
    .exp_word  (exp_word),
`ifdef BIST_FAIL_CAPTURE_EN
    .rd_addr   (addr),
    .fail_addr (fail_addr_o),
    .fail_data (fail_data_o),
`endif
    .rdata     (mem_rdata_i),
    .ready     (mem_ready_i),
    .err_cnt   (err_cnt_o)
  );

endmodule
